// File: rtl/morse_encoder.sv
// Replays a packed 10-bit Morse word (five 2-bit symbols, MSB pair first) as a
// timed on/off keying signal: dot/line marks, each followed by a fixed low gap.
module morse_encoder #(
    parameter int DOT_TICKS  = 25_000_000,
    parameter int LINE_TICKS = 75_000_000,
    parameter int GAP_TICKS  = 25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] code,
    output logic       signal_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] sym_count
);

    localparam int MAX_TICKS_DL = (DOT_TICKS > LINE_TICKS) ? DOT_TICKS : LINE_TICKS;
    localparam int MAX_TICKS    = (MAX_TICKS_DL > GAP_TICKS) ? MAX_TICKS_DL : GAP_TICKS;
    localparam int TW           = $clog2(MAX_TICKS + 1);

    localparam logic [TW-1:0] DOT_LOAD  = TW'(DOT_TICKS - 1);
    localparam logic [TW-1:0] LINE_LOAD = TW'(LINE_TICKS - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        MARK,
        GAP,
        DONE
    } state_t;

    state_t        state;
    logic [9:0]    sh;
    logic [2:0]    idx;
    logic [TW-1:0] timer;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sh        <= '0;
            idx       <= '0;
            timer     <= '0;
            sym_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh        <= code;
                        idx       <= 3'd5;
                        sym_count <= '0;
                        state     <= SCAN;
                    end
                end

                SCAN: begin
                    if (idx == 3'd0) begin
                        state <= DONE;
                    end else begin
                        sh  <= {sh[7:0], 2'b00};
                        idx <= idx - 3'd1;
                        // 00 is an empty slot and 10 is invalid; both fall through and stay in SCAN.
                        case (sh[9:8])
                            2'b01: begin
                                timer <= DOT_LOAD;
                                state <= MARK;
                            end
                            2'b11: begin
                                timer <= LINE_LOAD;
                                state <= MARK;
                            end
                            default: state <= SCAN;
                        endcase
                    end
                end

                MARK: begin
                    if (timer == '0) begin
                        timer     <= GAP_LOAD;
                        sym_count <= sym_count + 3'd1;
                        state     <= GAP;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                GAP: begin
                    if (timer == '0) state <= SCAN;
                    else             timer <= timer - TW'(1);
                end

                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decodes of the state register, so reset clears them without waiting for a clock.
    assign signal_out = (state == MARK);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule
